mem_router: RTL

Parametrised, registered successor to the combinational memory-map decoder. Sits between the CPU memory port and the peripheral slaves (bootloader ROM, SDRAM, GPU, PS/2, GPIO, HEX, test, SD card). It latches each request, decodes the target region, and holds a one-hot slave select until the slave signals ready. It returns read data with a single-cycle acknowledge, and reports unmapped or timed-out accesses as bus errors, with a fault-address capture.

---
 rtl/mem_router.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_router.sv
// mem_router: registered memory-map router between the CPU memory port and
// the peripheral slaves.
//
// A request is latched while idle, its region decoded from the top address
// bits, and a one-hot select is held until the chosen slave reports ready.
// The response is a single-cycle o_ack carrying o_err/o_rdata. Unmapped
// accesses and accesses that exceed TIMEOUT ACCESS cycles complete with
// o_err=1 and o_rdata=0. Each faulting access updates o_err_address and the
// saturating o_err_count.
//
// Handshake: i_req is sampled only on an edge where o_busy=0. o_busy is high
// from the cycle after acceptance through the o_ack cycle. Requests presented
// while busy are dropped. A slave completes by raising its own
// i_slave_ready[r] while its o_sel[r] is high. Ready on any other slave line
// has no effect.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req/i_we/i_address/i_wdata/i_be   master request
//   o_busy, o_ack, o_err, o_rdata       master status and response
//   o_sel, o_slave_*                    slave select and latched request
//   i_slave_ready, i_slave_rdata        per-slave completion and read data
//   o_err_address, o_err_count          fault capture
//   o_state                             FSM state (0 idle, 1 access, 2 resp)
module mem_router #(
  parameter int                    ADDR_W       = 32,
  parameter int                    DATA_W       = 32,
  parameter int                    N_REGIONS    = 8,
  parameter int                    REGION_SHIFT = 28,
  parameter logic [N_REGIONS-1:0]  REGION_MASK  = 8'hFF,
  parameter logic [ADDR_W-1:0]     BOOT_SIZE    = 32'h0000_2000,
  parameter int                    TIMEOUT      = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req,
  input  logic                        i_we,
  input  logic [ADDR_W-1:0]           i_address,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [DATA_W/8-1:0]         i_be,
  output logic                        o_busy,
  output logic                        o_ack,
  output logic                        o_err,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [N_REGIONS-1:0]        o_sel,
  output logic [ADDR_W-1:0]           o_slave_address,
  output logic [DATA_W-1:0]           o_slave_wdata,
  output logic                        o_slave_we,
  output logic [DATA_W/8-1:0]         o_slave_be,
  input  logic [N_REGIONS-1:0]        i_slave_ready,
  input  logic [N_REGIONS*DATA_W-1:0] i_slave_rdata,
  output logic [ADDR_W-1:0]           o_err_address,
  output logic [7:0]                  o_err_count,
  output logic [1:0]                  o_state
);

  localparam int RIDX_W = ADDR_W - REGION_SHIFT;
  // TIMEOUT=0 disables the timeout, but the counter still needs one bit.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The counter reads k-1 during the k-th ACCESS cycle, so the last allowed
  // cycle is the one where it holds TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_REGIONS-1:0] sel_q;
  logic [CNT_W-1:0]     tmo_cnt;

  logic [RIDX_W-1:0]    req_region;
  logic [N_REGIONS-1:0] req_sel;
  logic                 req_mapped;
  logic                 ready_hit;
  logic                 timeout_hit;
  logic [DATA_W-1:0]    slave_rdata_sel;

  // Region decode of the incoming address; region 0 (boot ROM) is further
  // limited to addresses below BOOT_SIZE.
  assign req_region = i_address[ADDR_W-1:REGION_SHIFT];

  always_comb begin
    req_sel = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      if ((req_region == RIDX_W'(r)) && REGION_MASK[r] &&
          ((r != 0) || (i_address < BOOT_SIZE))) begin
        req_sel[r] = 1'b1;
      end
    end
  end

  assign req_mapped = |req_sel;

  // Only the selected slave may complete the access.
  assign ready_hit   = |(i_slave_ready & sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

  always_comb begin
    slave_rdata_sel = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (sel_q[r]) begin
        slave_rdata_sel = slave_rdata_sel | i_slave_rdata[r*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          state_d = req_mapped ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        if (ready_hit || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The select is gated by the state so a reset or completion removes it on
  // the same edge that changes the state.
  assign o_busy  = (state_q != S_IDLE);
  assign o_ack   = (state_q == S_RESP);
  assign o_sel   = (state_q == S_ACCESS) ? sel_q : '0;
  assign o_state = state_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      sel_q           <= '0;
      tmo_cnt         <= '0;
      o_err           <= 1'b0;
      o_rdata         <= '0;
      o_slave_address <= '0;
      o_slave_wdata   <= '0;
      o_slave_we      <= 1'b0;
      o_slave_be      <= '0;
      o_err_address   <= '0;
      o_err_count     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (i_req) begin
            o_slave_address <= i_address;
            o_slave_wdata   <= i_wdata;
            o_slave_we      <= i_we;
            o_slave_be      <= i_be;
            sel_q           <= req_sel;
            tmo_cnt         <= '0;
            if (!req_mapped) begin
              o_err         <= 1'b1;
              o_rdata       <= '0;
              o_err_address <= i_address;
              o_err_count   <= (o_err_count == 8'hFF) ? 8'hFF : o_err_count + 8'd1;
            end
          end
        end
        S_ACCESS: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          // Ready takes priority over a timeout in the same cycle.
          if (ready_hit) begin
            o_err   <= 1'b0;
            o_rdata <= o_slave_we ? '0 : slave_rdata_sel;
          end else if (timeout_hit) begin
            o_err         <= 1'b1;
            o_rdata       <= '0;
            o_err_address <= o_slave_address;
            o_err_count   <= (o_err_count == 8'hFF) ? 8'hFF : o_err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
